// File: rtl/ps2mouse_device_funcmod.sv
`timescale 1ns/1ps
// Device-side PS/2 mouse transmitter: sends a 3-byte packet on open-drain
// PS2_CLK/PS2_DAT, backing off and retrying a byte whenever the host inhibits.
module ps2mouse_device_funcmod #(
  parameter int HALF = 2000,
  parameter int IDLE = 2500
) (
  input  logic        CLOCK,
  input  logic        RESET,
  inout  wire         PS2_CLK,
  inout  wire         PS2_DAT,
  input  logic        iEn,
  input  logic [23:0] iData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oAbort,
  output logic        oHostReq
);

  localparam int CNT_MAX = (HALF > IDLE) ? HALF : IDLE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] C_HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] C_HALF_MID = CW'(HALF / 2);
  localparam logic [CW-1:0] C_IDLE     = CW'(IDLE);
  localparam logic [CW-1:0] C_INH      = CW'(4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_BUS, S_HIGH, S_LOW, S_GAP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [1:0]    r_byte;
  logic [23:0]   r_data;
  logic          r_clk_low;
  logic          r_dat_low;
  logic          r_busy;
  logic          r_done;
  logic          r_abort;
  logic          r_clk_meta, r_clk_sync;
  logic          r_dat_meta, r_dat_sync;

  logic [7:0]    w_byte;
  logic [10:0]   w_frame;
  logic          w_bit;
  logic          w_bus_idle;

  assign PS2_CLK = r_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = r_dat_low ? 1'b0 : 1'bz;

  assign w_byte     = (r_byte == 2'd0) ? r_data[7:0] :
                      (r_byte == 2'd1) ? r_data[15:8] : r_data[23:16];
  assign w_frame    = {1'b1, ~^w_byte, w_byte, 1'b0};
  assign w_bit      = w_frame[r_bit];
  assign w_bus_idle = r_clk_sync & r_dat_sync;

  assign oBusy    = r_busy;
  assign oDone    = r_done;
  assign oAbort   = r_abort;
  assign oHostReq = (r_state == S_IDLE) & r_clk_sync & ~r_dat_sync;

  // Synchronizers rest at lines-high so a reset never looks like a host request.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= PS2_CLK;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= PS2_DAT;
      r_dat_sync <= r_dat_meta;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_data    <= '0;
      r_clk_low <= 1'b0;
      r_dat_low <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_clk_low <= 1'b0;
          r_dat_low <= 1'b0;
          // The oDone cycle still blocks a new start.
          if (iEn && !r_done) begin
            r_data  <= iData;
            r_byte  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_WAIT_BUS;
          end
        end
        S_WAIT_BUS: begin
          if (!w_bus_idle) begin
            r_cnt <= '0;
          end else if (r_cnt == C_IDLE) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          // Early cycles are skipped: our own clock release is still in the synchronizer.
          if (r_cnt >= C_INH && !r_clk_sync) begin
            r_clk_low <= 1'b0;
            r_dat_low <= 1'b0;
            r_abort   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_WAIT_BUS;
          end else if (r_cnt == C_HALF_END) begin
            r_clk_low <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_LOW;
          end else begin
            if (r_cnt == C_HALF_MID) begin
              r_dat_low <= ~w_bit;
            end
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (r_cnt == C_HALF_END) begin
            r_clk_low <= 1'b0;
            r_cnt     <= '0;
            if (r_bit < 4'd10) begin
              r_bit   <= r_bit + 1'b1;
              r_state <= S_HIGH;
            end else begin
              r_dat_low <= 1'b0;
              r_state   <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == C_HALF_END) begin
            r_cnt <= '0;
            if (r_byte < 2'd2) begin
              r_byte  <= r_byte + 1'b1;
              r_state <= S_WAIT_BUS;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2mouse_device_funcmod.sv
`timescale 1ns/1ps
// Directed bench for the PS/2 mouse transmitter: a passive host model decodes
// frames on PS2_CLK falling edges while directed steps exercise RTS, inhibit and reset.
module tb_ps2mouse_device_funcmod;

  localparam int HALF = 8;
  localparam int IDLE = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic [23:0] i_data = '0;
  logic        o_busy, o_done, o_abort, o_host_req;
  wire         ps2_clk, ps2_dat;
  logic        host_clk_low = 1'b0;
  logic        host_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;

  ps2mouse_device_funcmod #(.HALF(HALF), .IDLE(IDLE)) dut (
    .CLOCK   (clk),
    .RESET   (rst_n),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .iEn     (i_en),
    .iData   (i_data),
    .oBusy   (o_busy),
    .oDone   (o_done),
    .oAbort  (o_abort),
    .oHostReq(o_host_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`define CHECK(tag, got, exp) \
  begin \
    n_checks++; \
    assert ((got) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (got), (exp)); \
    end \
  end

`define CHECK_RANGE(tag, got, lo, hi) \
  begin \
    n_checks++; \
    assert ((got) >= (lo) && (got) <= (hi)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, (got), (lo), (hi)); \
    end \
  end

  // Passive host: shifts DAT in on every CLK fall the device produces.
  int          nbits = 0;
  int          n_falls = 0;
  logic [10:0] fbits = '0;
  time         last_fall = 0;
  logic [7:0]  rx_q[$];

  always @(negedge ps2_clk) begin
    n_falls++;
    if (host_clk_low) begin
      nbits = 0;
    end else begin
      if ($time - last_fall > 320) nbits = 0;
      last_fall = $time;
      fbits = {ps2_dat, fbits[10:1]};
      nbits++;
      if (nbits == 11) begin
        `CHECK("start_bit", fbits[0], 1'b0)
        `CHECK("stop_bit", fbits[10], 1'b1)
        `CHECK("odd_parity", ^fbits[9:1], 1'b1)
        rx_q.push_back(fbits[8:1]);
        $display("host rx byte %02h parity %0b at %0t", fbits[8:1], fbits[9], $time);
        nbits = 0;
      end
    end
  end

  // Cycle sampler: phase widths, DAT stability while CLK low, pulse counts.
  int   low_len = 0, hi_len = 0;
  int   n_done_cyc = 0, n_abort_cyc = 0;
  logic prev_clk = 1'b1, prev_dat = 1'b1;
  logic touched = 1'b0, skip_phase = 1'b0;

  always @(negedge clk) begin
    if (o_done === 1'b1) n_done_cyc++;
    if (o_abort === 1'b1) n_abort_cyc++;
    if (ps2_clk === 1'b1) begin
      if (prev_clk === 1'b0) begin
        if (!touched && !skip_phase) `CHECK("clk_low_phase", low_len, HALF)
        touched = 1'b0;
        hi_len  = 0;
      end
      hi_len++;
    end else begin
      if (prev_clk === 1'b1) begin
        if (!host_clk_low) begin
          n_checks++;
          assert (hi_len == HALF || hi_len >= IDLE) else begin
            n_fail++;
            $error("FAIL clk_high_phase: observed %0d cycles expected 8 or >=20", hi_len);
          end
        end
        low_len = 0;
      end else if (!host_clk_low && !touched) begin
        `CHECK("dat_stable_clk_low", ps2_dat, prev_dat)
      end
      if (host_clk_low || !rst_n) touched = 1'b1;
      low_len++;
    end
    prev_clk = ps2_clk;
    prev_dat = ps2_dat;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d);
    i_data = d;
    i_en   = 1'b1;
    step();
    i_en   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int  k;
    bit  busy_ok;
    busy_ok = 1'b1;
    for (k = 0; k < 3000; k++) begin
      if (o_done === 1'b1) break;
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      step();
    end
    `CHECK({tag, "_done_seen"}, o_done, 1'b1)
    `CHECK({tag, "_busy_held"}, busy_ok, 1'b1)
    `CHECK({tag, "_busy_drop_at_done"}, o_busy, 1'b0)
    $display("packet %s done after %0d cycles", tag, k);
  endtask

  task automatic check_rx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    `CHECK("rx_count", rx_q.size(), 3)
    for (int i = 0; i < 3; i++) begin
      logic [7:0] got;
      logic [7:0] exp;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      exp = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      `CHECK("rx_byte", got, exp)
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int lat;
    int falls0;

    // Reset state
    repeat (3) step();
    `CHECK("reset_busy", o_busy, 1'b0)
    `CHECK("reset_done", o_done, 1'b0)
    `CHECK("reset_abort", o_abort, 1'b0)
    `CHECK("reset_hostreq", o_host_req, 1'b0)
    `CHECK("reset_clk_released", ps2_clk, 1'b1)
    `CHECK("reset_dat_released", ps2_dat, 1'b1)
    rst_n = 1'b1;
    step();

    // Host RTS: DAT low, CLK high before iEn; device must hold off.
    host_dat_low = 1'b1;
    repeat (5) step();
    `CHECK("rts_hostreq", o_host_req, 1'b1)
    falls0 = n_falls;
    send(24'h0A1C08);
    `CHECK("rts_busy_after_en", o_busy, 1'b1)
    repeat (100) step();
    `CHECK("rts_no_clk_edges", n_falls - falls0, 0)
    n_done_cyc = 0;
    rx_q.delete();
    host_dat_low = 1'b0;
    lat = 0;
    while (ps2_clk === 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    `CHECK_RANGE("rts_start_latency", lat, 30, 32)
    $display("rts released, first clk low after %0d cycles", lat);

    // Second iEn while busy with different data must be ignored.
    repeat (10) step();
    send(24'hFFFFFF);
    wait_done("p1");

    // iEn coincident with oDone ignored; one cycle later accepted.
    i_data = 24'h123456;
    i_en   = 1'b1;
    step();
    `CHECK("en_at_done_ignored", o_busy, 1'b0)
    `CHECK("done_one_cycle", n_done_cyc, 1)
    `CHECK("done_low_after", o_done, 1'b0)
    check_rx(8'h08, 8'h1C, 8'h0A);
    rx_q.delete();
    n_done_cyc  = 0;
    n_abort_cyc = 0;
    i_data = 24'h0A1C08;
    step();
    i_en = 1'b0;
    `CHECK("en_after_done_accepted", o_busy, 1'b1)
    lat = 1;
    while (ps2_clk === 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    `CHECK_RANGE("start_latency", lat, 30, 32)
    $display("packet p2 started, first clk low after %0d cycles", lat);

    // Inhibit during bit 5 of byte1.
    k = 0;
    while (!(rx_q.size() == 1 && nbits == 5) && k < 2000) begin
      step();
      k++;
    end
    `CHECK("reach_byte1_bit5", (k < 2000), 1'b1)
    k = 0;
    while (ps2_clk !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    repeat (3) step();
    host_clk_low = 1'b1;
    k = 0;
    while (o_abort !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    `CHECK_RANGE("abort_latency", k, 1, 3)
    `CHECK("dat_released_on_abort", ps2_dat, 1'b1)
    $display("host inhibit, abort after %0d cycles", k);
    repeat (200 - k) step();
    host_clk_low = 1'b0;
    step();
    `CHECK("clk_released_after_inhibit", ps2_clk, 1'b1)
    wait_done("p2");
    step();
    `CHECK("abort_one_pulse", n_abort_cyc, 1)
    `CHECK("p2_done_one_cycle", n_done_cyc, 1)
    check_rx(8'h08, 8'h1C, 8'h0A);

    // Reset in the middle of byte0 while the device drives DAT low.
    repeat (5) step();
    rx_q.delete();
    send(24'h5AFF00);
    k = 0;
    while (!(rx_q.size() == 0 && nbits == 3) && k < 500) begin
      step();
      k++;
    end
    `CHECK("reach_byte0_bit3", (k < 500), 1'b1)
    k = 0;
    while (ps2_clk !== 1'b0 && k < 20) begin
      step();
      k++;
    end
    step();
    `CHECK("pre_reset_dat_driven", ps2_dat, 1'b0)
    skip_phase = 1'b1;
    rst_n = 1'b0;
    #1;
    `CHECK("midreset_clk_released", ps2_clk, 1'b1)
    `CHECK("midreset_dat_released", ps2_dat, 1'b1)
    `CHECK("midreset_busy", o_busy, 1'b0)
    `CHECK("midreset_abort", o_abort, 1'b0)
    `CHECK("midreset_hostreq", o_host_req, 1'b0)
    $display("reset asserted mid-byte0");
    repeat (5) step();
    rst_n = 1'b1;
    repeat (10) step();
    skip_phase = 1'b0;
    rx_q.delete();
    n_done_cyc = 0;
    send(24'h5AFF00);
    `CHECK("post_reset_busy", o_busy, 1'b1)
    wait_done("p3");
    step();
    `CHECK("p3_done_one_cycle", n_done_cyc, 1)
    check_rx(8'h00, 8'hFF, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

`undef CHECK
`undef CHECK_RANGE

endmodule

// File: doc/ps2mouse_device_funcmod.md
# ps2mouse_device_funcmod

Device-side PS/2 mouse transmitter: emulates the mouse end of the link. It generates PS2_CLK and PS2_DAT, transmitting a 3-byte movement packet to a PS/2 host such as the team's init/read host path. It gives the host side a self-contained stimulus source in loop-back builds, and can drive an external host. It handles bus inhibit and host request-to-send by backing off, and retries any byte aborted by inhibit.

## Interface
- HALF, 2000: CLOCK cycles per PS/2 clock half-period (50 MHz → 12.5 kHz); even, ≥8.
- IDLE, 2500: CLOCK cycles both lines must be seen high before a byte starts (50 µs).
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- PS2_CLK  inout  1  open-drain: driven 0 or released (Z), never driven 1.
- PS2_DAT  inout  1  open-drain, same rule.
- iEn  in  1  one-cycle start pulse; latches iData. Ignored while oBusy=1.
- iData  in  24  packet; byte0=iData[7:0], byte1=[15:8], byte2=[23:16], sent in that order.
- oBusy  out  1  high from the cycle after the accepted iEn until oDone.
- oDone  out  1  one-cycle pulse after byte2's stop bit and its final release.
- oAbort  out  1  one-cycle pulse per byte aborted by host inhibit.
- oHostReq  out  1  level: synchronized PS2_CLK=1 and PS2_DAT=0 while idle (host RTS).

## Operation
- PS2_CLK/PS2_DAT are sampled through 2-flop synchronizers; all decisions use the synchronized values.
- States: IDLE, WAIT_BUS, HIGH, LOW, GAP.
- IDLE: lines released. Accepted iEn latches iData, clears byte index to 0 and goes to WAIT_BUS.
- WAIT_BUS:
  - Counts consecutive cycles with both synchronized lines high.
  - Any low sample resets the count to 0.
  - When the count reaches IDLE, goes to HIGH with bit index 0.
  - Holds here indefinitely while the host inhibits or requests to send.
- Frame: 11 bits.
  - Bit 0: start bit, 0.
  - Bits 1–8: data, LSB first.
  - Bit 9: odd parity, so the 8 data bits plus the parity bit contain an odd number of 1s. Examples: 0x00 → parity 1; 0xFF → parity 1; 0x08 → parity 0.
  - Bit 10: stop bit, 1.
- HIGH, HALF cycles:
  - PS2_CLK released.
  - At cycle HALF/2, PS2_DAT is set to the current bit: 0 → drive low, 1 → release.
  - Then goes to LOW.
- LOW, HALF cycles:
  - PS2_CLK driven low; PS2_DAT held.
  - At the end, if bit index <10, increment it and go to HIGH.
  - Otherwise release both lines and go to GAP.
- Inhibit: in HIGH, from cycle 4 onward, a synchronized PS2_CLK=0 means the host is inhibiting. The block then:
  - releases both lines immediately;
  - pulses oAbort;
  - returns to WAIT_BUS with the same byte index, so the byte is retried in full.
- Inhibit is not checked during LOW, or after the falling edge of bit 10; the byte then counts as sent.
- GAP, HALF cycles, lines released:
  - if the byte index <2, increment it and go to WAIT_BUS;
  - otherwise pulse oDone, drop oBusy and go to IDLE.
- Reset (any time, including mid-frame): both lines released the same cycle. State IDLE; all counters 0; oBusy=0, oDone=0, oAbort=0. oHostReq follows its synchronizer, which resets to lines-high, so oHostReq=0.

## Timing
- iEn to first PS2_CLK low, bus idle: 1 (accept) + IDLE + 2 (sync) + HALF cycles, ±1.
- Bit cell: 2·HALF cycles. Byte on wire: 22·HALF cycles.
- Data changes only mid-high-phase. It is stable ≥HALF/2 before and HALF after each falling edge.
- Packet with no inhibit: 3·(IDLE + 23·HALF) cycles, plus synchronizer latency (≤8 cycles total).
- oDone and oAbort are exactly one cycle wide. oDone is coincident with oBusy falling.
- iEn in the same cycle as oDone is ignored. iEn one cycle later is accepted.

## Test plan
- HALF=8, IDLE=20, iData=0x0A1C08, passive host model sampling DAT on CLK falling edges.
  - Host receives bytes 0x08 (parity 0), 0x1C (parity 0), 0x0A (parity 1), each with start 0 and stop 1.
  - oDone pulses once; oBusy spans the whole packet.
- Byte timing check: CLK low and high phases are exactly 8 cycles. No DAT transition occurs while CLK is low. The gap between bytes is ≥20 cycles of both lines high.
- Inhibit: host pulls CLK low for 200 cycles during bit 5 of byte1.
  - oAbort pulses once; lines are released within 3 cycles.
  - Byte1 is resent in full after the bus has been idle for 20 cycles.
  - The host sees 0x08, 0x1C, 0x0A exactly once each.
- Host RTS: DAT held low and CLK high before iEn.
  - oHostReq=1; no CLK edges occur.
  - After DAT is released, transmission begins IDLE+2 cycles later.
- Reset: RESET asserted low mid-byte0.
  - Both lines are Z the same cycle; oBusy=0.
  - A new iEn after release sends a full fresh packet.
- iEn pulsed again while busy, with a different iData: ignored; the original packet is sent unchanged.
